// File: rtl/argmax_3_16.sv
// Streaming argmax head: consumes M signed words per vector, then emits the
// index of the maximum followed by the maximum value on a registered output.
module argmax_3_16 #(
  parameter int M = 3,
  parameter int T = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out
);

  localparam int logM = $clog2(M);
  localparam int logC = $clog2(M + 1);
  localparam logic [logC-1:0] LAST = logC'(M - 1);

  typedef enum logic [1:0] {
    ACC,
    OUT_IDX,
    OUT_VAL
  } state_t;

  state_t state, state_nxt;

  logic        [logC-1:0] cnt;
  logic        [logM-1:0] max_idx, idx_nxt;
  logic signed [T-1:0]    max_val, val_nxt;
  logic                   in_xfer, out_xfer;

  assign s_ready  = (state == ACC) && !reset;
  assign in_xfer  = s_valid && s_ready;
  assign out_xfer = m_valid && m_ready;

  // Running maximum including the current input word; word 0 always loads,
  // later words replace only when strictly greater so ties keep the lower index.
  always_comb begin
    idx_nxt = max_idx;
    val_nxt = max_val;
    if (cnt == '0 || data_in > max_val) begin
      idx_nxt = logM'(cnt);
      val_nxt = data_in;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACC;
    else       state <= state_nxt;
  end

  // Next-state logic: accumulate M words, then hand out index and value words.
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (in_xfer && cnt == LAST) state_nxt = OUT_IDX;
      OUT_IDX: if (out_xfer)               state_nxt = OUT_VAL;
      OUT_VAL: if (out_xfer)               state_nxt = ACC;
      default:                             state_nxt = ACC;
    endcase
  end

  // Datapath: counter, running max, and the registered output word/valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      max_idx  <= '0;
      max_val  <= '0;
      m_valid  <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        ACC: begin
          if (in_xfer) begin
            max_idx <= idx_nxt;
            max_val <= val_nxt;
            if (cnt == LAST) begin
              // Index word is loaded from the combinational max so it is
              // presented on the very edge the last word is accepted.
              cnt      <= '0;
              m_valid  <= 1'b1;
              data_out <= T'(idx_nxt);
            end else begin
              cnt <= cnt + logC'(1);
            end
          end
        end
        OUT_IDX: begin
          if (out_xfer) data_out <= max_val;
        end
        OUT_VAL: begin
          if (out_xfer) begin
            m_valid  <= 1'b0;
            data_out <= '0;
          end
        end
        default: begin
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_3_16.sv
// Directed self-checking bench for argmax_3_16.
module tb_argmax_3_16;

  logic               clk;
  logic               reset;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] data_in;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] data_out;

  int n_assert = 0;
  int n_fail   = 0;
  int unsigned cyc = 0;
  int unsigned t_prev, t_now;

  argmax_3_16 #(.M(3), .T(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] v);
    bit done = 0;
    s_valid = 1'b1;
    data_in = v;
    for (int i = 0; i < 20 && !done; i++) begin
      if (s_ready) done = 1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!done) begin
      n_assert++;
      n_fail++;
      $error("FAIL send_timeout observed=%h expected=accept", v);
    end
  endtask

  task automatic recv(input string tag, input logic [15:0] exp);
    bit done = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (m_valid) begin
        check(tag, data_out, exp);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_timeout observed=no_m_valid expected=%h", tag, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        bub_v [6];
    logic [15:0] bub_d [6];
    bub_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bub_d = '{16'd7, 16'h7FFF, 16'h7FFF, 16'd3, 16'h7FFF, 16'd8};

    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 16'd0);
    check("rst_m_valid", m_valid, 16'd0);
    check("rst_data_out", data_out, 16'h0000);
    reset = 1'b0;
    #1;
    check("post_rst_s_ready", s_ready, 16'd1);
    check("post_rst_m_valid", m_valid, 16'd0);
    @(posedge clk); #1;

    // [14, 83, 0] with m_ready held high; s_ready low for exactly 2 cycles
    m_ready = 1'b1;
    send(16'd14); send(16'd83); send(16'd0);
    check("v1_idx_valid", m_valid, 16'd1);
    check("v1_idx", data_out, 16'h0001);
    check("v1_sready0_a", s_ready, 16'd0);
    @(posedge clk); #1;
    check("v1_val", data_out, 16'h0053);
    check("v1_sready0_b", s_ready, 16'd0);
    @(posedge clk); #1;
    check("v1_sready1", s_ready, 16'd1);
    check("v1_done_valid", m_valid, 16'd0);
    check("v1_done_data", data_out, 16'h0000);

    // Ties keep the lowest index
    send(16'd5); send(16'd5); send(16'd5);
    recv("tie_idx", 16'h0000);
    recv("tie_val", 16'h0005);

    // Signed comparison
    send(16'hFFFD); send(16'hFFFF); send(16'hFFF9);
    recv("neg_idx", 16'h0001);
    recv("neg_val", 16'hFFFF);

    // Backpressure: outputs held stable while m_ready is low
    m_ready = 1'b0;
    send(16'd1); send(16'd2); send(16'd9);
    for (int i = 0; i < 4; i++) begin
      check("bp_idx_valid", m_valid, 16'd1);
      check("bp_idx", data_out, 16'h0002);
      check("bp_idx_sready", s_ready, 16'd0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_val_valid", m_valid, 16'd1);
      check("bp_val", data_out, 16'h0009);
      check("bp_val_sready", s_ready, 16'd0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_done_valid", m_valid, 16'd0);
    check("bp_done_sready", s_ready, 16'd1);

    // Input bubbles: only handshaken words count
    for (int i = 0; i < 6; i++) begin
      s_valid = bub_v[i];
      data_in = bub_d[i];
      if (i == 5) check("bub_not_early", m_valid, 16'd0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    recv("bub_idx", 16'h0002);
    recv("bub_val", 16'h0008);

    // Reset mid-vector discards the partial vector
    send(16'd100); send(16'd200);
    reset = 1'b1;
    #1;
    check("midrst_s_ready", s_ready, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 16'd0);
    check("midrst_data_out", data_out, 16'h0000);
    check("midrst_s_ready_back", s_ready, 16'd1);
    send(16'd4); send(16'd2); send(16'd1);
    recv("midrst_idx", 16'h0000);
    recv("midrst_val", 16'h0004);

    // Three back-to-back vectors: one result pair every M+2 = 5 cycles
    send(16'd10); send(16'd20); send(16'd30);
    t_prev = cyc;
    recv("b2b0_idx", 16'h0002);
    recv("b2b0_val", 16'h001E);
    send(16'hFFFB); send(16'd6); send(16'd6);
    t_now = cyc;
    check("b2b1_period", 16'(t_now - t_prev), 16'd5);
    t_prev = t_now;
    recv("b2b1_idx", 16'h0001);
    recv("b2b1_val", 16'h0006);
    send(16'h7FFF); send(16'h8000); send(16'd1);
    t_now = cyc;
    check("b2b2_period", 16'(t_now - t_prev), 16'd5);
    recv("b2b2_idx", 16'h0000);
    recv("b2b2_val", 16'h7FFF);
    check("final_valid", m_valid, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/argmax_3_16.md
# argmax_3_16

Streaming argmax stage that sits directly downstream of the 3-output, 16-bit fully-connected ReLU layer. It consumes each M-word output vector over a valid/ready input port and tracks the running maximum and its position. It then emits two words on a valid/ready output port: the index of the maximum, then the maximum value. It is the classification head of the network pipeline.

## Interface
- M, 3, words per input vector (M ≥ 2)
- T, 16, data word width (T > $clog2(M))
- logM, $clog2(M), index width
- logC, $clog2(M+1), input counter width

Ports:
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  asynchronous, active-high; clears all state immediately
- s_valid  input  1  upstream word valid
- s_ready  output  1  block accepts a word this cycle
- data_in  input  T  signed upstream word
- m_valid  output  1  data_out holds a valid word
- m_ready  input  1  downstream accepts data_out this cycle
- data_out  output  T  signed output word (index word, then value word)

## Operation
- Input transfer: s_valid && s_ready at a rising edge. Output transfer: m_valid && m_ready at a rising edge.
- FSM states: ACC, OUT_IDX, OUT_VAL. Reset state is ACC.
- ACC:
  - s_ready = 1 (combinational: state==ACC && !reset).
  - Each input transfer increments cnt.
  - Word 0 of a vector loads max_val ← data_in and max_idx ← 0 unconditionally.
  - Word k>0 updates the maximum only if data_in > max_val, compared as a signed T-bit comparison.
  - Ties keep the lower index.
  - The transfer with cnt==M-1 moves to OUT_IDX and clears cnt.
- OUT_IDX:
  - m_valid = 1; data_out = max_idx zero-extended to T bits.
  - s_ready = 0.
  - An output transfer moves to OUT_VAL.
- OUT_VAL:
  - m_valid = 1; data_out = max_val.
  - s_ready = 0.
  - An output transfer moves to ACC.
- m_valid and data_out are registered. While m_valid && !m_ready, both hold stable (no drop, no change).
- No overlap: a new vector is not accepted until the value word has transferred.
- Input bubbles (s_valid low in ACC) stall the counter; the result is unaffected.
- Reset mid-vector or mid-output:
  - The partial vector is discarded and the pending output is dropped.
  - cnt, max_idx, max_val and data_out are all cleared to 0; state returns to ACC.

## Timing
- Reset values: s_ready = 0 while reset is asserted, 1 in the first cycle after deassertion. m_valid = 0. data_out = 0.
- Latency: the last input word transfers at edge k. From edge k, m_valid = 1 with the index word.
- The value word is presented from the edge at which the index word transfers.
- s_ready rises from the edge at which the value word transfers.
- Peak throughput: M+2 cycles per vector, with s_valid and m_ready both held high.
- data_out returns to 0 on the edge that moves the FSM to ACC.
- Sequencing: no input and output transfer can occur in the same cycle.

## Test plan
- Vector [14, 83, 0], m_ready=1 → outputs 0x0001 then 0x0053. s_ready low for exactly 2 cycles.
- Tie vector [5, 5, 5] → outputs 0x0000 then 0x0005.
- Signed vector [-3, -1, -7] (0xFFFD, 0xFFFF, 0xFFF9) → outputs 0x0001 then 0xFFFF.
- Backpressure: vector [1, 2, 9] with m_ready low for 4 cycles at each word.
  - m_valid and data_out are stable throughout: 0x0002 held, then 0x0009 held.
  - s_ready stays 0.
- Input bubbles: s_valid toggles 1-0-0-1-0-1 for [7, 3, 8] → outputs 0x0002, 0x0008. Accepted words count only on handshakes.
- Reset mid-vector:
  - Stimulus: accept [100, 200], assert reset for 1 cycle, then send [4, 2, 1].
  - Required: outputs 0x0000, 0x0004; no output is produced for the aborted vector.
  - Follow with 3 back-to-back vectors, m_ready=1 → one result pair every 5 cycles.
